icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter NUM_LINES, 16, number of direct-mapped lines (power of 2, >=2), 128 bits each.
REQ-002 Parameter MEM_AW, 12, width of the backing-memory word address.
REQ-003 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-004 rstn_i  in  1  reset, synchronous, active-low.
REQ-005 req_i  in  1  core fetch request; held with addr_i until ready_o.
REQ-006 addr_i  in  32  core byte address; bits [1:0] ignored.
REQ-007 flush_i  in  1  invalidate all lines, 1-cycle pulse.
REQ-008 ready_o  out  1  data_o valid for the current request.
REQ-009 data_o  out  32  fetched word.
REQ-010 mem_re_o  out  1  backing-memory read enable.
REQ-011 mem_add_o  out  MEM_AW  line-aligned word address, low 2 bits always 0.
REQ-012 mem_ble_o  out  4  byte lanes, constant 4'hF.
REQ-013 mem_valid_i  in  1  refill line valid, single-cycle pulse.
REQ-014 mem_d_i  in  4x32  refill line, word k at [k].
REQ-015 hit_cnt_o, miss_cnt_o  out  32 each  statistics counters (REQ-032).

Function
REQ-016 Address split: word offset = addr_i[3:2], index = addr_i[4+IDX_W-1:4] with IDX_W = log2(NUM_LINES), tag = addr_i[MEM_AW+1:4+IDX_W]; bits above MEM_AW+1 ignored.
REQ-017 FSM states: IDLE, REFILL.
REQ-018 IDLE, req_i=1, valid[index]=1, tag match: hit; ready_o=1 and data_o=line word[offset] combinationally in the same cycle; stay IDLE.
REQ-019 IDLE, req_i=1, miss: ready_o=0; register the line address; go REFILL next cycle.
REQ-020 REFILL: mem_re_o=1 continuously, mem_add_o={tag,index,2'b00} of the registered address; mem_re_o never dropped before mem_valid_i.
REQ-021 REFILL, mem_valid_i=1: write mem_d_i to line, store tag, set valid bit, go IDLE; mem_re_o=0 from the next cycle.
REQ-022 Refilled request is served as a hit in the first IDLE cycle after refill; miss latency = memory latency + 2 cycles from request to ready_o.
REQ-023 Changes of req_i/addr_i during REFILL do not abort the refill; the registered address is used.
REQ-024 mem_valid_i in IDLE is ignored.
REQ-025 flush_i in IDLE: all valid bits cleared at the clock edge; a concurrent request in that cycle is treated as a miss.
REQ-026 flush_i in REFILL: recorded; on refill completion all valid bits are cleared and the refilled line is not installed; the pending request then misses again.
REQ-027 ready_o=0 whenever req_i=0; data_o=0 whenever ready_o=0.

Reset
REQ-028 rstn_i=0 at an edge: state IDLE, all valid bits 0, pending flush 0, counters 0.
REQ-029 Outputs during/after reset: ready_o=0, data_o=0, mem_re_o=0, mem_add_o=0, mem_ble_o=4'hF.
REQ-030 Reset mid-REFILL abandons the refill; mem_re_o=0 from the cycle after the reset edge; a subsequent mem_valid_i is ignored.
REQ-031 Line data and tag storage need no reset.

Configuration
REQ-032 Macro ICACHE_STATS_EN defined: hit_cnt_o increments once per hit cycle with ready_o=1 (served refills included), miss_cnt_o once per IDLE->REFILL transition; both wrap at 2^32.
REQ-033 ICACHE_STATS_EN undefined: no counter registers; hit_cnt_o and miss_cnt_o tied to 0.

Structure
REQ-034 Package icache_pkg holds the state enum, LINE_WORDS=4, and address field width functions.
REQ-035 Sub-module icache_line_array: tag/data storage with one combinational read port and one synchronous write port; valid bits, FSM and counters stay in icache_dm.

Verification
REQ-036 Cold fetch 0x0000_0104, memory latency 5, line {D3,D2,D1,D0}: mem_re_o high 6 cycles at mem_add_o=0x040, ready_o with data_o=D1 at cycle 7; miss_cnt_o=1.
REQ-037 Then fetch 0x100,0x104,0x108,0x10C back-to-back: four single-cycle hits returning D0..D3; hit_cnt_o=5.
REQ-038 Conflict: fetch 0x0000_0104 then 0x0000_0204 (same index, different tag, NUM_LINES=16): second misses and refills; refetch 0x104 misses again.
REQ-039 flush_i pulsed during refill of 0x300: refill completes, request misses again and issues a second refill at mem_add_o=0x0C0.
REQ-040 rstn_i=0 for 1 cycle mid-refill: mem_re_o=0 next cycle; late mem_valid_i ignored; refetch of the same address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped icache.
// Holds the FSM state enum, the line size and field-width functions.
package icache_pkg;

    typedef enum logic [0:0] {
        S_IDLE,
        S_REFILL
    } state_e;

    localparam int LINE_WORDS = 4;
    localparam int IDX_LSB    = 4;

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag covers byte-address bits [mem_aw+1 : IDX_LSB+idx_w].
    function automatic int tag_w(input int mem_aw, input int num_lines);
        return mem_aw + 2 - IDX_LSB - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch and refill bus of the icache: core request side plus memory side.
// slave: cache view; master: environment (core + backing memory) view.
interface icache_if
    import icache_pkg::*;
#(
    parameter int MEM_AW = 12
) ();

    logic                             req_i;
    logic [31:0]                      addr_i;
    logic                             flush_i;
    logic                             ready_o;
    logic [31:0]                      data_o;
    logic                             mem_re_o;
    logic [MEM_AW-1:0]                mem_add_o;
    logic [3:0]                       mem_ble_o;
    logic                             mem_valid_i;
    logic [LINE_WORDS-1:0][31:0]      mem_d_i;

    modport slave (
        input  req_i, addr_i, flush_i, mem_valid_i, mem_d_i,
        output ready_o, data_o, mem_re_o, mem_add_o, mem_ble_o
    );

    modport master (
        output req_i, addr_i, flush_i, mem_valid_i, mem_d_i,
        input  ready_o, data_o, mem_re_o, mem_add_o, mem_ble_o
    );

endinterface

// File: rtl/icache_line_array.sv
// Tag and data storage: one combinational read port, one clocked write port.
// Ports: clk_i, rd_idx_i -> rd_tag_o/rd_line_o, we_i/wr_idx_i/wr_tag_i/wr_line_i.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 6
) (
    input  logic                        clk_i,
    input  logic [IDX_W-1:0]            rd_idx_i,
    output logic [TAG_W-1:0]            rd_tag_o,
    output logic [LINE_WORDS-1:0][31:0] rd_line_o,
    input  logic                        we_i,
    input  logic [IDX_W-1:0]            wr_idx_i,
    input  logic [TAG_W-1:0]            wr_tag_i,
    input  logic [LINE_WORDS-1:0][31:0] wr_line_i
);

    logic [TAG_W-1:0]            tag_q  [NUM_LINES];
    logic [LINE_WORDS-1:0][31:0] data_q [NUM_LINES];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_line_i;
        end
    end

    assign rd_tag_o  = tag_q[rd_idx_i];
    assign rd_line_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, 4-word lines, single refill in flight.
// Ports: clk_i, rstn_i (sync, active-low), bus (icache_if.slave),
// hit_cnt_o/miss_cnt_o statistics (live only with ICACHE_STATS_EN defined).
module icache_dm
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int MEM_AW    = 12
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    icache_if.slave     bus,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(MEM_AW, NUM_LINES);
    localparam int LA_W  = TAG_W + IDX_W;

    state_e                      state_q, state_d;
    logic [NUM_LINES-1:0]        valid_q, valid_d;
    logic                        fpend_q, fpend_d;
    logic [LA_W-1:0]             la_q, la_d;

    logic [1:0]                  off;
    logic [IDX_W-1:0]            idx;
    logic [TAG_W-1:0]            tag;
    logic [IDX_W-1:0]            la_idx;
    logic [TAG_W-1:0]            la_tag;
    logic [TAG_W-1:0]            rd_tag;
    logic [LINE_WORDS-1:0][31:0] rd_line;
    logic                        hit;
    logic                        re;
    logic                        line_we;
    logic                        miss_go;
    logic                        unused_addr;

    assign off    = bus.addr_i[3:2];
    assign idx    = bus.addr_i[IDX_LSB +: IDX_W];
    assign tag    = bus.addr_i[IDX_LSB+IDX_W +: TAG_W];
    assign la_idx = la_q[IDX_W-1:0];
    assign la_tag = la_q[LA_W-1:IDX_W];

    assign unused_addr = ^{bus.addr_i[1:0], bus.addr_i[31:MEM_AW+2]};

    icache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk_i     (clk_i),
        .rd_idx_i  (idx),
        .rd_tag_o  (rd_tag),
        .rd_line_o (rd_line),
        .we_i      (line_we),
        .wr_idx_i  (la_idx),
        .wr_tag_i  (la_tag),
        .wr_line_i (bus.mem_d_i)
    );

    // A flush in the same cycle forces a miss on the concurrent request.
    assign hit = rstn_i && (state_q == S_IDLE) && bus.req_i
              && !bus.flush_i && valid_q[idx] && (rd_tag == tag);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        fpend_d = fpend_q;
        la_d    = la_q;
        re      = 1'b0;
        line_we = 1'b0;
        miss_go = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.flush_i) valid_d = '0;
                if (bus.req_i && !hit) begin
                    state_d = S_REFILL;
                    la_d    = {tag, idx};
                    miss_go = 1'b1;
                end
            end
            S_REFILL: begin
                re = 1'b1;
                if (bus.flush_i) fpend_d = 1'b1;
                if (bus.mem_valid_i) begin
                    state_d = S_IDLE;
                    fpend_d = 1'b0;
                    // A flush seen during the refill discards the new line.
                    if (fpend_q || bus.flush_i) begin
                        valid_d = '0;
                    end else begin
                        line_we         = rstn_i;
                        valid_d[la_idx] = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            fpend_q <= 1'b0;
            la_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            fpend_q <= fpend_d;
            la_q    <= la_d;
        end
    end

    assign bus.ready_o   = hit;
    assign bus.data_o    = hit ? rd_line[off] : '0;
    assign bus.mem_re_o  = rstn_i && re;
    assign bus.mem_add_o = bus.mem_re_o ? {la_q, 2'b00} : '0;
    assign bus.mem_ble_o = 4'hF;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'd0, hit};
        miss_cnt_d = miss_cnt_q + {31'd0, miss_go};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = miss_go;
    assign hit_cnt_o    = '0;
    assign miss_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus random traffic
// compared every cycle against a residency-map model of the cache.
module tb_icache_dm;
    import icache_pkg::*;

    localparam int NL  = 16;
    localparam int AW  = 12;
    localparam int LAW = AW - 2;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] hc, mc;

    always #5 clk = ~clk;

    icache_if #(.MEM_AW(AW)) bus ();

    icache_dm #(.NUM_LINES(NL), .MEM_AW(AW)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .bus        (bus),
        .hit_cnt_o  (hc),
        .miss_cnt_o (mc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Backing memory: word at word address wa holds C0DE_0xxx.
    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        return {16'hC0DE, 4'h0, wa[11:0]};
    endfunction

    function automatic logic [31:0] st(input logic [31:0] v);
`ifdef ICACHE_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // ---------------- memory responder ----------------
    logic                  resp_v = 1'b0;
    logic                  inj_v  = 1'b0;
    logic [3:0][31:0]      resp_d = '0;
    logic [3:0][31:0]      inj_d  = '0;
    int                    lat = 5;
    int                    cnt = 0;
    int                    re_cycles = 0;
    int                    sessions = 0;
    logic [AW-1:0]         last_add = '0;
    bit                    rand_lat = 0;
    bit                    spur_en = 0;
    bit                    prev_re = 0;

    assign bus.mem_valid_i = resp_v | inj_v;
    assign bus.mem_d_i     = inj_v ? inj_d : resp_d;

    initial forever begin
        @(negedge clk);
        #1;
        resp_v = 1'b0;
        if (bus.mem_re_o) begin
            if (!prev_re) begin
                sessions++;
                cnt = 0;
                if (rand_lat) lat = $urandom_range(0, 4);
            end
            re_cycles++;
            cnt++;
            last_add = bus.mem_add_o;
            if (cnt > lat) begin
                resp_v = 1'b1;
                for (int k = 0; k < 4; k++)
                    resp_d[k] = mem_word({20'd0, bus.mem_add_o} + k);
                cnt = 0;
            end
        end else if (spur_en && $urandom_range(0, 19) == 0) begin
            resp_v = 1'b1;
            for (int k = 0; k < 4; k++) resp_d[k] = $urandom;
        end
        prev_re = bus.mem_re_o;
    end

    // ---------------- reference model ----------------
    int          res [NL];
    bit          m_ok = 0;
    bit          m_ref = 0;
    bit          m_fp = 0;
    int          m_la = 0;
    logic [31:0] m_hits = 0;
    logic [31:0] m_miss = 0;

    function automatic int la_of(input logic [31:0] a);
        return int'((a >> 4) & ((32'd1 << LAW) - 1));
    endfunction

    function automatic bit m_hit();
        int la;
        la = la_of(bus.addr_i);
        return rstn && !m_ref && bus.req_i && !bus.flush_i
            && res[la % NL] == la / NL;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NL; i++) res[i] = -1;
    endtask

    task automatic m_step();
        bit h;
        if (!rstn) begin
            m_ok = 1; m_ref = 0; m_fp = 0;
            m_hits = 0; m_miss = 0;
            m_clear();
        end else if (!m_ref) begin
            h = m_hit();
            if (bus.flush_i) m_clear();
            if (h) m_hits++;
            else if (bus.req_i) begin
                m_ref = 1;
                m_la = la_of(bus.addr_i);
                m_miss++;
            end
        end else begin
            if (bus.flush_i) m_fp = 1;
            if (bus.mem_valid_i) begin
                m_ref = 0;
                if (m_fp) m_clear();
                else res[m_la % NL] = m_la / NL;
                m_fp = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        bit er, ere;
        @(negedge clk);
        #2;
        if (m_ok) begin
            er  = m_hit();
            ere = rstn && m_ref;
            check("ready", {31'd0, bus.ready_o}, {31'd0, er});
            check("data", bus.data_o, er ? mem_word((bus.addr_i >> 2) & 32'hFFF) : 32'd0);
            check("mem_re", {31'd0, bus.mem_re_o}, {31'd0, ere});
            check("mem_add", {20'd0, bus.mem_add_o}, ere ? m_la * 4 : 0);
            check("mem_ble", {28'd0, bus.mem_ble_o}, 32'hF);
            check("hit_cnt", hc, st(m_hits));
            check("miss_cnt", mc, st(m_miss));
        end
    end

    // ---------------- stimulus ----------------
    int          fn;
    logic [31:0] fd;
    int          s0;
    bit          last_ready = 0;
    logic [31:0] ra;

    task automatic fetch(input logic [31:0] a, input int budget);
        @(negedge clk);
        bus.req_i  = 1'b1;
        bus.addr_i = a;
        fn = 0;
        fd = 0;
        forever begin
            #3;
            if (bus.ready_o) begin
                fd = bus.data_o;
                return;
            end
            fn++;
            if (fn > budget) begin
                check("fetch_timeout", fn, budget);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            bus.req_i   = 1'b0;
            bus.flush_i = 1'b0;
        end
    endtask

    initial begin
        bus.req_i   = 1'b0;
        bus.addr_i  = '0;
        bus.flush_i = 1'b0;

        repeat (2) @(negedge clk);
        #3;
        check("rst_ready", {31'd0, bus.ready_o}, 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        check("rst_mem_re", {31'd0, bus.mem_re_o}, 32'd0);
        check("rst_mem_add", {20'd0, bus.mem_add_o}, 32'd0);
        check("rst_ble", {28'd0, bus.mem_ble_o}, 32'hF);
        check("rst_hit_cnt", hc, 32'd0);
        check("rst_miss_cnt", mc, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Cold miss, latency 5.
        lat = 5;
        re_cycles = 0;
        fetch(32'h0000_0104, 60);
        check("cold_latency", fn, 7);
        check("cold_data", fd, 32'hC0DE_0041);
        check("cold_re_cycles", re_cycles, 6);
        check("cold_mem_add", {20'd0, last_add}, 32'h040);
        check("cold_miss_cnt", mc, st(32'd1));

        // Back-to-back hits across the line.
        for (int i = 0; i < 4; i++) begin
            fetch(32'h100 + 4 * i, 60);
            check("b2b_latency", fn, 0);
            check("b2b_data", fd, 32'hC0DE_0040 + i);
        end
        idle(1);
        #3;
        check("b2b_hit_cnt", hc, st(32'd5));

        // Conflict on index 0.
        fetch(32'h0000_0204, 60);
        check("conf_latency", fn, 7);
        check("conf_data", fd, 32'hC0DE_0081);
        fetch(32'h0000_0104, 60);
        check("conf_refetch_latency", fn, 7);
        check("conf_refetch_data", fd, 32'hC0DE_0041);
        check("conf_miss_cnt", mc, st(32'd3));
        idle(1);

        // Flush during refill of 0x300.
        s0 = sessions;
        fork
            fetch(32'h0000_0300, 80);
            begin
                repeat (3) @(negedge clk);
                bus.flush_i = 1'b1;
                @(negedge clk);
                bus.flush_i = 1'b0;
            end
        join
        check("flush_latency", fn, 14);
        check("flush_data", fd, 32'hC0DE_00C0);
        check("flush_sessions", sessions - s0, 2);
        check("flush_mem_add", {20'd0, last_add}, 32'h0C0);
        idle(1);
        fetch(32'h0000_0104, 60);
        check("post_flush_latency", fn, 7);
        idle(1);

        // Reset in the middle of a refill.
        @(negedge clk);
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0000_0400;
        repeat (3) @(negedge clk);
        rstn      = 1'b0;
        bus.req_i = 1'b0;
        @(negedge clk);
        rstn  = 1'b1;
        inj_v = 1'b1;
        for (int k = 0; k < 4; k++) inj_d[k] = mem_word(32'h100 + k);
        #3;
        check("rst_mid_mem_re", {31'd0, bus.mem_re_o}, 32'd0);
        @(negedge clk);
        inj_v = 1'b0;
        fetch(32'h0000_0400, 60);
        check("rst_refetch_latency", fn, 7);
        check("rst_refetch_data", fd, 32'hC0DE_0100);
        idle(2);

        // Random traffic.
        rand_lat = 1;
        spur_en  = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rstn        = ($urandom_range(0, 299) != 0);
            bus.flush_i = ($urandom_range(0, 39) == 0);
            if (!bus.req_i || last_ready || $urandom_range(0, 15) == 0) begin
                ra = $urandom;
                ra[13:8] = 6'($urandom_range(0, 3));
                ra[7:4]  = 4'($urandom_range(0, 3));
                bus.req_i  = ($urandom_range(0, 9) < 7);
                bus.addr_i = ra;
            end
            #3;
            last_ready = bus.ready_o;
        end
        rand_lat = 0;
        spur_en  = 0;
        rstn     = 1'b1;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
